// File: rtl/disp_vramctrl_if.sv
// AXI4 read-address / read-data channel bundle between the display fetch controller
// and the VRAM interconnect.
interface disp_vramctrl_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/disp_vramctrl.sv
// Display VRAM fetch controller: AXI4 read master streaming one frame from VRAM into the
// display FIFO in fixed-length bursts, one burst in flight, paced by the FIFO's space flag.
module disp_vramctrl #(
    parameter int H_PIX     = 640,
    parameter int V_PIX     = 480,
    parameter int BURST_LEN = 16
) (
    input  logic            ACLK,
    input  logic            ARST,
    input  logic            DISPON,
    input  logic            VSTART,
    input  logic [28:0]     DISPADDR,
    input  logic            BUF_WREADY,
    disp_vramctrl_if.master axi,
    output logic            FIFOWR,
    output logic [63:0]     FIFOIN,
    output logic            RD_ERR
);
    localparam int WORDS       = H_PIX * V_PIX / 2;
    localparam int NBURST      = WORDS / BURST_LEN;
    localparam int BCW         = $clog2(NBURST + 1);
    localparam int BURST_BYTES = BURST_LEN * 8;
    localparam logic [BCW-1:0] NBURST_C = BCW'(NBURST);

    typedef enum logic [1:0] {
        IDLE,
        WAITBUF,
        SETADDR,
        READ
    } state_t;

    state_t          state_q, state_d;
    logic [28:0]     base_q, base_d;
    logic [BCW-1:0]  burst_q, burst_d;
    logic [BCW-1:0]  burst_inc;
    logic [31:0]     araddr_q, araddr_d;
    logic            fifowr_q, fifowr_d;
    logic [63:0]     fifoin_q, fifoin_d;
    logic            rd_err_q, rd_err_d;

    assign burst_inc = burst_q + BCW'(1);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        burst_d  = burst_q;
        araddr_d = araddr_q;
        fifowr_d = 1'b0;
        fifoin_d = fifoin_q;
        rd_err_d = rd_err_q;

        case (state_q)
            IDLE: begin
                if (DISPON && VSTART) begin
                    base_d   = DISPADDR;
                    burst_d  = '0;
                    rd_err_d = 1'b0;
                    state_d  = WAITBUF;
                end
            end
            WAITBUF: begin
                if (!DISPON) begin
                    state_d = IDLE;
                end else if (BUF_WREADY) begin
                    // Address wraps modulo 2^32 by construction of the 32-bit sum.
                    araddr_d = {base_q, 3'b000} + 32'(burst_q) * 32'(BURST_BYTES);
                    state_d  = SETADDR;
                end
            end
            SETADDR: begin
                if (axi.ARREADY) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (axi.RVALID) begin
                    fifowr_d = 1'b1;
                    fifoin_d = axi.RDATA;
                    if (axi.RRESP != 2'b00) begin
                        rd_err_d = 1'b1;
                    end
                    // DISPON is only honoured at burst boundaries so every accepted burst lands in full.
                    if (axi.RLAST) begin
                        burst_d = burst_inc;
                        if (burst_inc == NBURST_C || !DISPON) begin
                            state_d = IDLE;
                        end else begin
                            state_d = WAITBUF;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q  <= IDLE;
            base_q   <= '0;
            burst_q  <= '0;
            araddr_q <= '0;
            fifowr_q <= 1'b0;
            fifoin_q <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            burst_q  <= burst_d;
            araddr_q <= araddr_d;
            fifowr_q <= fifowr_d;
            fifoin_q <= fifoin_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign axi.ARADDR  = araddr_q;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = 3'b011;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = (state_q == SETADDR);
    assign axi.RREADY  = (state_q == READ);

    assign FIFOWR = fifowr_q;
    assign FIFOIN = fifoin_q;
    assign RD_ERR = rd_err_q;
endmodule

// File: tb/tb_disp_vramctrl.sv
// Bench for disp_vramctrl: a VRAM slave with configurable AR/R timing plus a frame-level
// reference model (address of the n-th word = base + 8n) checking every AR and FIFO write.
module tb_disp_vramctrl;
    localparam int H_PIX     = 64;
    localparam int V_PIX     = 8;
    localparam int BURST_LEN = 16;
    localparam int WORDS     = H_PIX * V_PIX / 2;
    localparam int NBURST    = WORDS / BURST_LEN;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic        DISPON;
    logic        VSTART;
    logic [28:0] DISPADDR;
    logic        BUF_WREADY;
    logic        FIFOWR;
    logic [63:0] FIFOIN;
    logic        RD_ERR;

    disp_vramctrl_if axi ();

    disp_vramctrl #(
        .H_PIX    (H_PIX),
        .V_PIX    (V_PIX),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .ACLK      (ACLK),
        .ARST      (ARST),
        .DISPON    (DISPON),
        .VSTART    (VSTART),
        .DISPADDR  (DISPADDR),
        .BUF_WREADY(BUF_WREADY),
        .axi       (axi),
        .FIFOWR    (FIFOWR),
        .FIFOIN    (FIFOIN),
        .RD_ERR    (RD_ERR)
    );

    initial forever #5 ACLK = ~ACLK;

    int checks_total  = 0;
    int checks_passed = 0;

    // Frame model state
    logic [28:0] frame_base = '0;
    int          ar_idx      = 0;
    int          wr_idx      = 0;
    int          ar_hs_cnt   = 0;
    int          r_hs_cnt    = 0;
    int          overlap_cnt = 0;
    int          ar_wait_cur = 0;
    logic        model_err   = 1'b0;
    logic [31:0] last_araddr = '0;

    // Stimulus knobs
    logic        err_en     = 1'b0;
    logic [31:0] err_addr   = '0;
    logic        ar_rand    = 1'b0;
    int          ar_delay   = 0;
    logic        rv_rand    = 1'b0;
    logic        bufw_rand  = 1'b0;
    logic        bufw_force = 1'b1;

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'hC3C3_5A5A, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [28:0] base);
        @(posedge ACLK);
        #1;
        frame_base = base;
        ar_idx     = 0;
        wr_idx     = 0;
        ar_hs_cnt  = 0;
        r_hs_cnt   = 0;
        model_err  = 1'b0;
        DISPADDR   = base;
        DISPON     = 1'b1;
        VSTART     = 1'b1;
        @(posedge ACLK);
        #1;
        VSTART = 1'b0;
    endtask

    task automatic pulseVstart(input logic [28:0] addr);
        @(posedge ACLK);
        #1;
        DISPADDR = addr;
        VSTART   = 1'b1;
        @(posedge ACLK);
        #1;
        VSTART = 1'b0;
    endtask

    task automatic waitBeats(input string tag, input int beats);
        int cyc;
        cyc = 0;
        while (r_hs_cnt < beats && cyc < 3000) begin
            @(posedge ACLK);
            cyc++;
        end
        #1;
        checkOutput(tag, 64'(r_hs_cnt >= beats), 64'd1);
    endtask

    task automatic waitFrameDone(input string tag);
        int cyc;
        cyc = 0;
        while (wr_idx < WORDS && cyc < 6000) begin
            @(posedge ACLK);
            cyc++;
        end
        repeat (30) @(posedge ACLK);
        #1;
        checkOutput({tag, "_words"}, 64'(wr_idx), 64'(WORDS));
        checkOutput({tag, "_bursts"}, 64'(ar_idx), 64'(NBURST));
        checkOutput({tag, "_ar_hs"}, 64'(ar_hs_cnt), 64'(NBURST));
        checkOutput({tag, "_idle_arvalid"}, 64'(axi.ARVALID), 64'd0);
        checkOutput({tag, "_idle_rready"}, 64'(axi.RREADY), 64'd0);
    endtask

    // FIFO space flag: either forced by the scenario or randomly toggling
    initial begin
        BUF_WREADY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            BUF_WREADY = bufw_rand ? ($urandom_range(0, 3) != 0) : bufw_force;
        end
    end

    // VRAM slave: samples handshakes at the negedge before each active edge, updates after it
    initial begin : slave
        logic        ar_hs;
        logic        r_hs;
        logic        pending;
        logic [31:0] ar_addr_s;
        logic [31:0] cur_addr;
        logic [31:0] a;
        int          beat;
        int          ar_cnt;
        int          ar_need;
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RDATA   = '0;
        axi.RRESP   = 2'b00;
        axi.RLAST   = 1'b0;
        pending  = 1'b0;
        cur_addr = '0;
        beat     = 0;
        ar_cnt   = 0;
        ar_need  = 0;
        forever begin
            @(negedge ACLK);
            ar_hs     = axi.ARVALID && axi.ARREADY;
            r_hs      = axi.RVALID && axi.RREADY;
            ar_addr_s = axi.ARADDR;
            @(posedge ACLK);
            #1;
            if (ARST) begin
                pending     = 1'b0;
                beat        = 0;
                ar_cnt      = 0;
                axi.ARREADY = 1'b0;
                axi.RVALID  = 1'b0;
                axi.RLAST   = 1'b0;
                axi.RRESP   = 2'b00;
            end else begin
                if (r_hs) begin
                    beat++;
                    if (beat == BURST_LEN) begin
                        pending = 1'b0;
                        beat    = 0;
                    end
                end
                if (ar_hs) begin
                    pending  = 1'b1;
                    cur_addr = ar_addr_s;
                    beat     = 0;
                end
                axi.ARREADY = 1'b0;
                if (axi.ARVALID && !pending && !ar_hs) begin
                    if (ar_cnt == 0) ar_need = ar_rand ? int'($urandom_range(0, 3)) : ar_delay;
                    if (ar_cnt >= ar_need) axi.ARREADY = 1'b1;
                    ar_cnt++;
                end else begin
                    ar_cnt = 0;
                end
                if (pending && (!rv_rand || $urandom_range(0, 3) != 0)) begin
                    a          = cur_addr + 32'(beat * 8);
                    axi.RVALID = 1'b1;
                    axi.RDATA  = data_of(a);
                    axi.RLAST  = (beat == BURST_LEN - 1);
                    axi.RRESP  = (err_en && a == err_addr) ? 2'b10 : 2'b00;
                end else begin
                    axi.RVALID = 1'b0;
                    axi.RLAST  = 1'b0;
                    axi.RRESP  = 2'b00;
                end
            end
        end
    end

    // Frame-level reference: n-th AR of a frame targets base + n*burst, n-th FIFO word is base + 8n
    initial begin : monitor
        logic        prev_arvalid;
        logic        prev_hs;
        logic        prev_bufw;
        logic [31:0] prev_araddr;
        logic [31:0] exp_a;
        prev_arvalid = 1'b0;
        prev_hs      = 1'b0;
        prev_bufw    = 1'b0;
        prev_araddr  = '0;
        forever begin
            @(negedge ACLK);
            if (ARST) begin
                prev_arvalid = 1'b0;
                prev_hs      = 1'b0;
            end else begin
                if (axi.ARVALID && axi.RREADY) overlap_cnt++;
                if (axi.ARVALID && (!prev_arvalid || prev_hs)) begin
                    exp_a = {frame_base, 3'b000} + 32'(ar_idx * BURST_LEN * 8);
                    checkOutput("araddr", 64'(axi.ARADDR), 64'(exp_a));
                    checkOutput("ar_after_bufw", 64'(prev_bufw), 64'd1);
                    checkOutput("arlen", 64'(axi.ARLEN), 64'(BURST_LEN - 1));
                    ar_idx++;
                    last_araddr = axi.ARADDR;
                    ar_wait_cur = 0;
                end else if (axi.ARVALID && prev_arvalid) begin
                    checkOutput("araddr_hold", 64'(axi.ARADDR), 64'(prev_araddr));
                end
                if (axi.ARVALID && !axi.ARREADY) ar_wait_cur++;
                if (axi.ARVALID && axi.ARREADY) begin
                    ar_hs_cnt++;
                    if (!ar_rand) checkOutput("ar_wait", 64'(ar_wait_cur), 64'(ar_delay));
                end
                if (axi.RVALID && axi.RREADY) r_hs_cnt++;
                if (FIFOWR) begin
                    exp_a = {frame_base, 3'b000} + 32'(wr_idx * 8);
                    if (err_en && exp_a == err_addr) model_err = 1'b1;
                    checkOutput("fifoin", FIFOIN, data_of(exp_a));
                    checkOutput("rd_err", 64'(RD_ERR), 64'(model_err));
                    wr_idx++;
                end
                prev_arvalid = axi.ARVALID;
                prev_hs      = axi.ARVALID && axi.ARREADY;
                prev_araddr  = axi.ARADDR;
            end
            prev_bufw = BUF_WREADY;
        end
    end

    initial begin : main
        logic [28:0] base;
        int          ar_before;
        int          cyc;
        ARST     = 1'b1;
        DISPON   = 1'b0;
        VSTART   = 1'b0;
        DISPADDR = '0;
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("rst_arvalid", 64'(axi.ARVALID), 64'd0);
        checkOutput("rst_rready", 64'(axi.RREADY), 64'd0);
        checkOutput("rst_fifowr", 64'(FIFOWR), 64'd0);
        checkOutput("rst_fifoin", FIFOIN, 64'd0);
        checkOutput("rst_araddr", 64'(axi.ARADDR), 64'd0);
        checkOutput("rst_rd_err", 64'(RD_ERR), 64'd0);
        checkOutput("arsize", 64'(axi.ARSIZE), 64'd3);
        checkOutput("arburst", 64'(axi.ARBURST), 64'd1);
        ARST = 1'b0;

        // VSTART without DISPON must not start a frame
        pulseVstart(29'h0040_0000);
        repeat (20) @(posedge ACLK);
        #1;
        checkOutput("vstart_no_dispon", 64'(ar_idx), 64'd0);

        // Nominal frame, everything always ready
        applyStimulus(29'h0200_0000);
        waitFrameDone("s1");
        checkOutput("s1_last_araddr", 64'(last_araddr), 64'h1000_0000 + 64'((NBURST - 1) * BURST_LEN * 8));

        // FIFO space stall after burst 3
        applyStimulus(29'h0300_0010);
        cyc = 0;
        while (ar_idx < 4 && cyc < 2000) begin
            @(posedge ACLK);
            cyc++;
        end
        #1;
        bufw_force = 1'b0;
        ar_before  = ar_idx;
        repeat (50) @(posedge ACLK);
        #1;
        checkOutput("s2_stall_no_ar", 64'(ar_idx), 64'(ar_before));
        checkOutput("s2_stall_arvalid", 64'(axi.ARVALID), 64'd0);
        bufw_force = 1'b1;
        cyc = 0;
        while (ar_idx < 5 && cyc < 200) begin
            @(posedge ACLK);
            cyc++;
        end
        #1;
        checkOutput("s2_burst4_addr", 64'(last_araddr), 64'({29'h0300_0010, 3'b000} + 32'h200));
        waitFrameDone("s2");

        // ARREADY held off 7 cycles per burst
        ar_delay = 7;
        applyStimulus(29'h0123_4560);
        waitFrameDone("s3");
        ar_delay = 0;

        // DISPON drops on beat 5 of burst 2
        applyStimulus(29'h0050_0000);
        waitBeats("s4_reach_beat", 2 * BURST_LEN + 5);
        DISPON = 1'b0;
        repeat (80) @(posedge ACLK);
        #1;
        checkOutput("s4_words_written", 64'(wr_idx), 64'(3 * BURST_LEN));
        checkOutput("s4_no_more_ar", 64'(ar_idx), 64'd3);
        checkOutput("s4_arvalid_low", 64'(axi.ARVALID), 64'd0);

        // Error response on one beat: sticky for the frame, cleared by the next frame start
        err_en   = 1'b1;
        err_addr = {29'h0060_0000, 3'b000} + 32'(20 * 8);
        applyStimulus(29'h0060_0000);
        waitFrameDone("s5");
        checkOutput("s5_rd_err_sticky", 64'(RD_ERR), 64'd1);
        err_en = 1'b0;
        applyStimulus(29'h0070_0000);
        checkOutput("s5_rd_err_cleared", 64'(RD_ERR), 64'd0);
        waitFrameDone("s5b");

        // Mid-frame VSTART is ignored, then reset lands mid-burst
        err_en   = 1'b1;
        err_addr = {29'h0080_0000, 3'b000} + 32'(3 * 8);
        applyStimulus(29'h0080_0000);
        waitBeats("s6_reach_vstart", 20);
        pulseVstart(29'h0DEA_D000);
        waitBeats("s6_reach_mid", 2 * BURST_LEN + 6);
        checkOutput("s6_err_before_rst", 64'(RD_ERR), 64'd1);
        checkOutput("s6_no_restart", 64'(ar_idx), 64'd3);
        @(posedge ACLK);
        #3;
        ARST = 1'b1;
        #1;
        checkOutput("s6_arvalid", 64'(axi.ARVALID), 64'd0);
        checkOutput("s6_rready", 64'(axi.RREADY), 64'd0);
        checkOutput("s6_fifowr", 64'(FIFOWR), 64'd0);
        checkOutput("s6_fifoin", FIFOIN, 64'd0);
        checkOutput("s6_araddr", 64'(axi.ARADDR), 64'd0);
        checkOutput("s6_rd_err", 64'(RD_ERR), 64'd0);
        repeat (3) @(posedge ACLK);
        #1;
        ARST   = 1'b0;
        err_en = 1'b0;
        ar_before = ar_idx;
        repeat (20) @(posedge ACLK);
        #1;
        checkOutput("s6_idle_after_rst", 64'(ar_idx), 64'(ar_before));

        // Randomized frames: random timing, random base (one forced to wrap past 2^32)
        ar_rand   = 1'b1;
        rv_rand   = 1'b1;
        bufw_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            base     = (f == 0) ? 29'h1FFF_FF80 : 29'($urandom);
            err_en   = ($urandom_range(0, 1) == 1);
            err_addr = {base, 3'b000} + 32'($urandom_range(0, WORDS - 1) * 8);
            applyStimulus(base);
            waitFrameDone("rand");
            checkOutput("rand_rd_err", 64'(RD_ERR), 64'(err_en));
        end

        checkOutput("ar_r_exclusive", 64'(overlap_cnt), 64'd0);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
